// File: rtl/y_isa_pkg.sv
// Shared MIPS subset encodings, ALU op codes and sequencer state type
// for the single-cycle datapath control.
package y_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem2reg;
        logic [2:0] op;
    } ctrl_t;

    // Safe "no side effects" control word used whenever nothing may retire.
    localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD};

endpackage

// File: rtl/y_decode.sv
// Combinational main decoder: instruction word to datapath controls,
// branch/jump flags, jump index and an illegal-encoding flag.
module y_decode
    import y_isa_pkg::*;
(
    input  logic [31:0] ins,
    output ctrl_t       ctrl,
    output logic        is_beq,
    output logic        is_j,
    output logic [25:0] jidx,
    output logic        illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = ins[31:26];
    assign funct  = ins[5:0];
    assign jidx   = ins[25:0];

    always_comb begin
        ctrl    = CTRL_NOP;
        is_beq  = 1'b0;
        is_j    = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.op = ALU_ADD;
                    FN_SUB:  ctrl.op = ALU_SUB;
                    FN_AND:  ctrl.op = ALU_AND;
                    FN_OR:   ctrl.op = ALU_OR;
                    FN_SLT:  ctrl.op = ALU_SLT;
                    default: begin
                        ctrl    = CTRL_NOP;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.mem2reg   = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.op = ALU_SUB;
                is_beq  = 1'b1;
            end
            OP_J:    is_j = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/y_seq_ctrl.sv
// Sequencer for the single-cycle MIPS datapath: owns the PC, gates decoded
// controls to retiring cycles only, and halts after a fixed instruction budget.
module y_seq_ctrl
    import y_isa_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd128,
    parameter int          MAX_INSN = 43,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic [31:0]      ins,
    input  logic             zero,
    input  logic [31:0]      imm,
    output logic [31:0]      pc,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Mem2Reg,
    output logic [2:0]       op,
    output logic             running,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INSN);

    seq_state_t       state, state_nx;
    ctrl_t            dec_ctrl, ctrl_out;
    logic             dec_beq, dec_j, dec_illegal;
    logic [25:0]      jidx;
    logic             active, retire, reload;
    logic [31:0]      pc4, npc;
    logic [CNT_W-1:0] retired_inc;

    y_decode u_decode (
        .ins     (ins),
        .ctrl    (dec_ctrl),
        .is_beq  (dec_beq),
        .is_j    (dec_j),
        .jidx    (jidx),
        .illegal (dec_illegal)
    );

    assign active      = (state == ST_RUN) && !stall;
    assign retire      = active && !dec_illegal;
    assign reload      = (state != ST_RUN) && start;
    assign retired_inc = retired + CNT_W'(1);

    assign pc4 = pc + 32'd4;
    always_comb begin
        npc = pc4;
        if (dec_beq && zero)
            npc = pc4 + (imm << 2);
        else if (dec_j)
            npc = {pc4[31:28], jidx, 2'b00};
    end

    // Nothing reaches the register file or memory unless this cycle retires.
    assign ctrl_out = retire ? dec_ctrl : CTRL_NOP;
    assign RegDst   = ctrl_out.reg_dst;
    assign RegWrite = ctrl_out.reg_write;
    assign ALUSrc   = ctrl_out.alu_src;
    assign MemRead  = ctrl_out.mem_read;
    assign MemWrite = ctrl_out.mem_write;
    assign Mem2Reg  = ctrl_out.mem2reg;
    assign op       = ctrl_out.op;

    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start)
                    state_nx = (MAX_INSN == 0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (active && (dec_illegal || retired_inc == MAX_CNT))
                    state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_nx;
            if (reload) begin
                pc      <= RESET_PC;
                retired <= '0;
                illegal <= 1'b0;
            end else if (retire) begin
                pc      <= npc;
                retired <= retired_inc;
            end else if (active) begin
                illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_y_seq_ctrl.sv
// Directed bench for y_seq_ctrl: one instance with the default budget for
// decode/branch/stall/illegal/reset, one with a budget of 4 for halting.
module tb_y_seq_ctrl;
    import y_isa_pkg::*;

    localparam logic [31:0] I_ADD  = 32'h00A41020;
    localparam logic [31:0] I_BEQ3 = 32'h10000003;
    localparam logic [31:0] I_J    = 32'h08000020;
    localparam logic [31:0] I_SW   = 32'hAC410000;
    localparam logic [31:0] I_LW   = 32'h8C410000;
    localparam logic [31:0] I_ADDI = 32'h20010005;
    localparam logic [31:0] I_ILL  = 32'hFC000000;

    logic clk, rst_n;

    logic        a_start, a_stall, a_zero;
    logic [31:0] a_ins, a_imm, a_pc;
    logic        a_RegDst, a_RegWrite, a_ALUSrc, a_MemRead, a_MemWrite, a_Mem2Reg;
    logic [2:0]  a_op;
    logic        a_running, a_done, a_illegal;
    logic [15:0] a_retired;

    logic        b_start, b_stall, b_zero;
    logic [31:0] b_ins, b_imm, b_pc;
    logic        b_RegDst, b_RegWrite, b_ALUSrc, b_MemRead, b_MemWrite, b_Mem2Reg;
    logic [2:0]  b_op;
    logic        b_running, b_done, b_illegal;
    logic [15:0] b_retired;

    int n_checks = 0;
    int n_errors = 0;

    y_seq_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .stall(a_stall), .ins(a_ins),
        .zero(a_zero), .imm(a_imm), .pc(a_pc), .RegDst(a_RegDst), .RegWrite(a_RegWrite),
        .ALUSrc(a_ALUSrc), .MemRead(a_MemRead), .MemWrite(a_MemWrite), .Mem2Reg(a_Mem2Reg),
        .op(a_op), .running(a_running), .done(a_done), .illegal(a_illegal), .retired(a_retired)
    );

    y_seq_ctrl #(.MAX_INSN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .stall(b_stall), .ins(b_ins),
        .zero(b_zero), .imm(b_imm), .pc(b_pc), .RegDst(b_RegDst), .RegWrite(b_RegWrite),
        .ALUSrc(b_ALUSrc), .MemRead(b_MemRead), .MemWrite(b_MemWrite), .Mem2Reg(b_Mem2Reg),
        .op(b_op), .running(b_running), .done(b_done), .illegal(b_illegal), .retired(b_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        a_start = 0; a_stall = 0; a_zero = 0; a_ins = I_ADD; a_imm = 0;
        b_start = 0; b_stall = 0; b_zero = 0; b_ins = I_ADDI; b_imm = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",       a_pc, 32'd128);
        check("rst_running",  a_running, 0);
        check("rst_done",     a_done, 0);
        check("rst_retired",  a_retired, 0);
        check("rst_illegal",  a_illegal, 0);
        check("rst_regwrite", a_RegWrite, 0);
        check("rst_op",       a_op, 3'b010);
        check("rst_b_pc",     b_pc, 32'd128);

        rst_n = 1'b1;
        a_start = 1; tick(); a_start = 0;
        check("start_running", a_running, 1);
        check("start_pc", a_pc, 32'd128);

        a_ins = I_ADD; #1;
        check("add_regdst", a_RegDst, 1);
        check("add_regwrite", a_RegWrite, 1);
        check("add_op", a_op, 3'b010);
        tick();
        check("add_pc", a_pc, 32'd132);
        check("add_retired", a_retired, 1);

        a_ins = I_BEQ3; a_zero = 1; a_imm = 32'd3; #1;
        check("beq_op", a_op, 3'b110);
        check("beq_regwrite", a_RegWrite, 0);
        check("beq_memwrite", a_MemWrite, 0);
        tick();
        check("beq_taken_pc", a_pc, 32'd148);
        check("beq_retired", a_retired, 2);

        a_ins = I_J; a_zero = 0; tick();
        check("j_pc", a_pc, 32'd128);
        check("j_retired", a_retired, 3);

        a_ins = I_ADD; tick();
        check("add2_pc", a_pc, 32'd132);

        a_ins = I_SW; a_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_memwrite", a_MemWrite, 0);
            tick();
            check("stall_pc", a_pc, 32'd132);
            check("stall_retired", a_retired, 4);
        end
        a_stall = 0; #1;
        check("sw_memwrite", a_MemWrite, 1);
        check("sw_alusrc", a_ALUSrc, 1);
        tick();
        check("sw_pc", a_pc, 32'd136);
        check("sw_retired", a_retired, 5);

        a_ins = I_BEQ3; a_zero = 0; tick();
        check("beq_nt_pc", a_pc, 32'd140);

        a_ins = I_LW; #1;
        check("lw_memread", a_MemRead, 1);
        check("lw_mem2reg", a_Mem2Reg, 1);
        tick();
        check("lw_pc", a_pc, 32'd144);
        check("lw_retired", a_retired, 7);

        a_ins = I_ILL; #1;
        check("ill_regwrite", a_RegWrite, 0);
        check("ill_memwrite", a_MemWrite, 0);
        check("ill_op", a_op, 3'b010);
        tick();
        check("ill_flag", a_illegal, 1);
        check("ill_done", a_done, 1);
        check("ill_running", a_running, 0);
        check("ill_pc", a_pc, 32'd144);
        check("ill_retired", a_retired, 7);
        a_ins = I_ADD; tick();
        check("ill_pc_frozen", a_pc, 32'd144);
        check("done_regwrite", a_RegWrite, 0);

        a_start = 1; tick(); a_start = 0;
        check("restart_running", a_running, 1);
        check("restart_pc", a_pc, 32'd128);
        check("restart_retired", a_retired, 0);
        check("restart_illegal", a_illegal, 0);
        tick();
        check("run2_pc", a_pc, 32'd132);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", a_pc, 32'd128);
        check("async_rst_running", a_running, 0);
        check("async_rst_retired", a_retired, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", a_running, 0);
        check("post_rst_pc", a_pc, 32'd128);

        b_start = 1; tick(); b_start = 0;
        b_ins = I_ADDI; tick();
        check("b_pc1", b_pc, 32'd132);
        b_start = 1; tick();
        check("b_start_ignored_pc", b_pc, 32'd136);
        check("b_start_ignored_ret", b_retired, 2);
        b_start = 0; tick();
        check("b_pc3_done", b_done, 0);
        check("b_pc3_running", b_running, 1);
        tick();
        check("b_final_pc", b_pc, 32'd144);
        check("b_final_retired", b_retired, 4);
        check("b_final_done", b_done, 1);
        check("b_final_running", b_running, 0);
        check("b_done_regwrite", b_RegWrite, 0);
        tick();
        check("b_frozen_pc", b_pc, 32'd144);

        b_start = 1; tick(); b_start = 0;
        check("b_restart_pc", b_pc, 32'd128);
        check("b_restart_retired", b_retired, 0);
        check("b_restart_running", b_running, 1);
        repeat (3) tick();
        check("b_pre_branch_pc", b_pc, 32'd140);
        b_ins = I_BEQ3; b_zero = 1; b_imm = 32'd3; tick();
        check("b_branch_last_pc", b_pc, 32'd156);
        check("b_branch_last_done", b_done, 1);
        check("b_branch_last_ret", b_retired, 4);
        tick();
        check("b_branch_frozen_pc", b_pc, 32'd156);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
